fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 5-stage RV32I pipeline. Owns the program counter, issues word-aligned read requests to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a small queue. The queue feeds the IF/ID pipeline registers through a valid/ready output. A taken-branch redirect from the MEM stage flushes the queue and discards any in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- QUEUE_DEPTH, 2, instruction queue entries; power of two, at least 2

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  taken branch from MEM stage
- redirect_pc  in  32  branch target
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts (not stalled)
- out_pc  out  32  PC of head instruction
- out_instr  out  32  head instruction
- fetch_fault  out  1  misaligned redirect seen (see Configuration)

## Operation
- State: pc, outstanding (0/1), drop (0/1), queue (count, rd_ptr, wr_ptr), req_pc (address of the in-flight request).
- Memory contract: exactly one response per accepted request, in order, no earlier than the cycle after acceptance. At most one request is in flight.
- Request condition: imem_req_valid = !redirect_valid && !fault && (!outstanding || imem_rsp_valid) && (count - pop + outstanding < QUEUE_DEPTH), where pop = out_valid && out_ready.
- Request handshake (valid && ready): req_pc <= pc; pc <= pc + 4 (32-bit wrap); outstanding <= 1.
- Response: if drop = 0, push {req_pc, imem_rsp_data}; outstanding clears unless a new request is accepted in the same cycle. If drop = 1, discard the response and clear drop.
- Pop: on out_valid && out_ready, advance rd_ptr. Push and pop in the same cycle leaves count unchanged.
- Redirect (highest priority):
  - pc <= {redirect_pc[31:2], 2'b00}; queue flushed (count, rd_ptr, wr_ptr <= 0).
  - If outstanding && !imem_rsp_valid: drop <= 1.
  - If a response arrives in the redirect cycle, it is discarded.
  - A pop in the redirect cycle still completes at decode; the queue is flushed regardless.
- Queue never overflows, by credit. A response never arrives while the queue is full.

## Timing
- Reset values:
  - Outputs: imem_req_valid 0 during reset; out_valid 0, out_pc 0, out_instr 0, fetch_fault 0.
  - State: pc = RESET_PC, outstanding 0, drop 0, count 0.
- Cycle 0 after reset deassert: imem_req_valid = 1, imem_req_addr = RESET_PC.
- Latency: response in cycle N, then out_valid in cycle N+1 (registered queue, no bypass).
- Throughput: one instruction per cycle with 1-cycle memory and out_ready held high.
- imem_req_addr = pc, stable while imem_req_valid && !imem_req_ready.
- After a redirect in cycle R: the first request is at R+1 with addr = target, unless a stale response is still pending, in which case it issues in the cycle that response arrives.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault (sticky until reset).
  - The queue is flushed, no further requests are issued, and out_valid stays 0.
- Undefined: redirect_pc[1:0] is ignored and fetch_fault is tied to 0.

## Structure
- Shared define header fetch_defs.v holds: XLEN (32), INSTR_NOP (32'h0000_0013), and the `TRUE/`FALSE encodings already used by decode.
- Sub-module fetch_queue: synchronous FIFO of {pc, instr}.
  - Ports: push, pop, flush, head outputs, count.
  - Parameterised by QUEUE_DEPTH.

## Test plan
- Reset, memory ready with 1-cycle response, out_ready = 1 -> addresses 0x0, 0x4, 0x8 on consecutive cycles; out_pc 0x0 at cycle 2, then one instruction per cycle.
- out_ready = 0 for 5 cycles -> exactly QUEUE_DEPTH (2) entries buffered and imem_req_valid = 0. On release, in-order out_pc 0x0, 0x4, then fetch resumes at 0x8.
- imem_req_ready = 0 for 3 cycles -> imem_req_addr held at the same value; no duplicate or skipped PC.
- Redirect to 0x40 while a request to 0x10 is in flight with a 2-cycle response -> the 0x10 response is discarded, queue empty, next out_pc = 0x40.
- Redirect in the same cycle as a response -> response discarded; the next request addr = target in the following cycle.
- FETCH_MISALIGN_CHECK_EN, redirect to 0x42 -> fetch_fault = 1, no requests, out_valid = 0 until reset; without the macro, fetch proceeds at 0x40.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fetch_unit_pkg
// Description : Shared constants, the queue entry type and a PC alignment
//               helper for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // Architectural register / address width.
  localparam int XLEN = 32;

  // One buffered fetch: the instruction word together with its PC.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a 4-byte boundary by clearing the two low bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of {pc, instr} entries sitting between the
//               fetch request logic and the IF/ID registers. Registered head,
//               no write-to-read bypass. Flush clears all pointers at once.
//               QUEUE_DEPTH must be a power of two so the pointers wrap for
//               free.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [XLEN-1:0]              push_pc_i,
  input  logic [XLEN-1:0]              push_instr_i,
  input  logic                         pop_i,
  output logic                         head_valid_o,
  output logic [XLEN-1:0]              head_pc_o,
  output logic [XLEN-1:0]              head_instr_o,
  output logic [$clog2(QUEUE_DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [QUEUE_DEPTH];
  fetch_entry_t     head_entry;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; flush overrides any push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q].pc    <= push_pc_i;
      mem_q[wr_ptr_q].instr <= push_instr_i;
    end
  end

  assign head_entry   = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0);
  assign head_pc_o    = head_valid_o ? head_entry.pc    : '0;
  assign head_instr_o = head_valid_o ? head_entry.instr : '0;
  assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction fetch stage. Owns the PC, issues one
//               word-aligned request at a time to instruction memory, and
//               buffers responses in fetch_queue. Requests are credit-limited
//               so a response always has a free queue slot. A MEM-stage
//               redirect flushes the queue and drops any in-flight response.
// Config      : FETCH_MISALIGN_CHECK_EN - when defined, a redirect to a
//               non-word-aligned target raises a sticky fetch_fault and halts
//               fetching until reset. Otherwise the low target bits are
//               cleared and fetch_fault is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            fetch_fault
);

  localparam int                 CNT_W     = $clog2(QUEUE_DEPTH) + 1;
  localparam int                 OCC_W     = CNT_W + 1;
  localparam logic [OCC_W-1:0]   DEPTH_OCC = OCC_W'(QUEUE_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;
  logic             fault;
  logic             pop;
  logic             push;
  logic             req_fire;
  logic [CNT_W-1:0] q_count;
  logic [OCC_W-1:0] occupancy;

  // Slots already claimed once this cycle's pop retires: queued entries plus
  // the in-flight request. A new request is allowed only if a slot remains.
  assign pop       = out_valid && out_ready;
  assign occupancy = OCC_W'(q_count) + OCC_W'(outstanding_q) - OCC_W'(pop);

  // A response arriving this cycle frees the single outstanding slot, so a
  // back-to-back request may go out alongside it.
  assign imem_req_valid = !reset && !redirect_valid && !fault &&
                          (!outstanding_q || imem_rsp_valid) &&
                          (occupancy < DEPTH_OCC);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Only a live (not dropped) response outside a redirect cycle is queued.
  assign push = imem_rsp_valid && outstanding_q && !drop_q && !redirect_valid;

  // PC, in-flight tracking and stale-response drop; redirect takes priority.
  always_comb begin
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (imem_rsp_valid && outstanding_q) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    if (req_fire) begin
      req_pc_d      = pc_q;
      pc_d          = pc_q + 32'd4;
      outstanding_d = 1'b1;
    end
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
      if (outstanding_q && !imem_rsp_valid) drop_d = 1'b1;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Sticky fault on any redirect whose target is not word aligned.
  always_comb begin
    fault_d = fault_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
  end

  // Fault register; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign fetch_fault = fault;

  fetch_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_pc_i    (req_pc_q),
    .push_instr_i (imem_rsp_data),
    .pop_i        (pop),
    .head_valid_o (out_valid),
    .head_pc_o    (out_pc),
    .head_instr_o (out_instr),
    .count_o      (q_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. A behavioural
//               instruction memory returns addr ^ 32'hA500_0013 after a
//               programmable latency. Inputs change 1 time unit after the
//               rising edge; outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;
  int lat    = 1;

  logic        hs_seen = 1'b0;
  logic [31:0] hs_addr = 32'h0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          rem = 0;

  always #5 clock = ~clock;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA500_0013;
  endfunction

  // Memory: note the handshake mid-cycle, respond lat cycles later.
  always @(negedge clock) begin
    hs_seen = imem_req_valid && imem_req_ready && !reset;
    hs_addr = imem_req_addr;
  end

  always @(posedge clock) begin
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (reset) begin
      pend = 1'b0;
      rem  = 0;
    end else begin
      if (hs_seen) begin
        pend      = 1'b1;
        rem       = lat;
        pend_addr = hs_addr;
      end
      if (pend) begin
        rem = rem - 1;
        if (rem == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(pend_addr);
          pend           = 1'b0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    lat            = 1;
    repeat (3) next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) next_cycle();
    mid();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
    end
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got valid=%b pc=%h instr=%h expected 0/0/0", out_valid, out_pc, out_instr);
    end
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault: got %b expected 0", fetch_fault);
    end
    next_cycle();
    reset = 1'b0;
    mid();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      mid();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_req cyc%0d: got valid=%b addr=%h expected 1/%h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
      end
      checks++;
      if (k < 2) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_out_early cyc%0d: got valid=%b expected 0", k, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 2)) || out_instr !== instr_of(32'(4 * (k - 2)))) begin
        errors++;
        $display("FAIL stream_out cyc%0d: got valid=%b pc=%h instr=%h expected 1/%h/%h", k, out_valid, out_pc, out_instr, 32'(4 * (k - 2)), instr_of(32'(4 * (k - 2))));
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mid();
      if (k >= 2) begin
        checks++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
          errors++;
          $display("FAIL bp_hold cyc%0d: got req=%b out_valid=%b pc=%h expected 0/1/00000000", k, imem_req_valid, out_valid, out_pc);
        end
      end
      next_cycle();
    end
    out_ready = 1'b1;
    mid();
    checks++;
    if (out_pc !== 32'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      errors++;
      $display("FAIL bp_release: got pc=%h req=%b addr=%h expected 00000000/1/00000008", out_pc, imem_req_valid, imem_req_addr);
    end
    next_cycle();
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
      errors++;
      $display("FAIL bp_second: got valid=%b pc=%h expected 1/00000004", out_valid, out_pc);
    end
    next_cycle();
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8) begin
      errors++;
      $display("FAIL bp_resume: got valid=%b pc=%h expected 1/00000008", out_valid, out_pc);
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) imem_req_ready = 1'b1;
      mid();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got valid=%b addr=%h expected 1/00000000", k, imem_req_valid, imem_req_addr);
      end
      next_cycle();
    end
    mid();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_next: got valid=%b addr=%h out_valid=%b expected 1/00000004/0", imem_req_valid, imem_req_addr, out_valid);
    end
    next_cycle();
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL stall_out0: got valid=%b pc=%h expected 1/00000000", out_valid, out_pc);
    end
    next_cycle();
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
      errors++;
      $display("FAIL stall_out4: got valid=%b pc=%h expected 1/00000004", out_valid, out_pc);
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    lat = 2;
    repeat (8) next_cycle();
    mid();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
      errors++;
      $display("FAIL rdi_pre: got valid=%b addr=%h expected 1/00000010", imem_req_valid, imem_req_addr);
    end
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hC || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdi_redirect: got valid=%b pc=%h req=%b expected 1/0000000c/0", out_valid, out_pc, imem_req_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
      errors++;
      $display("FAIL rdi_stale_rsp: got out_valid=%b req=%b addr=%h expected 0/1/00000040", out_valid, imem_req_valid, imem_req_addr);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      mid();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rdi_empty step%0d: got valid=%b pc=%h expected valid 0", k, out_valid, out_pc);
      end
    end
    next_cycle();
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== instr_of(32'h40)) begin
      errors++;
      $display("FAIL rdi_target: got valid=%b pc=%h instr=%h expected 1/00000040/%h", out_valid, out_pc, out_instr, instr_of(32'h40));
    end
  endtask

  task automatic test_redirect_with_rsp();
    do_reset();
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdr_redirect: got valid=%b pc=%h req=%b expected 1/00000004/0", out_valid, out_pc, imem_req_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdr_next_req: got req=%b addr=%h out_valid=%b expected 1/00000080/0", imem_req_valid, imem_req_addr, out_valid);
    end
    next_cycle();
    mid();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdr_discard: got valid=%b pc=%h expected valid 0", out_valid, out_pc);
    end
    next_cycle();
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h80) begin
      errors++;
      $display("FAIL rdr_target: got valid=%b pc=%h expected 1/00000080", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    mid();
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: got valid=%b addr=%h expected 1/fffffffc", imem_req_valid, imem_req_addr);
    end
    next_cycle();
    mid();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_zero: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
    next_cycle();
    mid();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_out: got valid=%b pc=%h expected 1/fffffffc", out_valid, out_pc);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    mid();
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    checks++;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_fault: got fault=%b req=%b expected 1/0", fetch_fault, imem_req_valid);
    end
`else
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
      errors++;
      $display("FAIL misalign_ignored: got fault=%b req=%b addr=%h expected 0/1/00000040", fetch_fault, imem_req_valid, imem_req_addr);
    end
`endif
    repeat (2) next_cycle();
    mid();
    checks++;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_halt: got fault=%b out_valid=%b req=%b expected 1/0/0", fetch_fault, out_valid, imem_req_valid);
    end
`else
    if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
      errors++;
      $display("FAIL misalign_out: got valid=%b pc=%h expected 1/00000040", out_valid, out_pc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_wrap();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
